// File: rtl/uart_receiver.sv
// UART receive path: 16x-oversampled deserialiser with parity/stop checks, FWFT RX FIFO
// and detection of a remote configuration request (line held low for 10 ms).
module uart_receiver #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ov_baud_rt_i,
  input  logic       rx_i,
  input  logic [1:0] data_width_i,
  input  logic [1:0] stop_bits_number_i,
  input  logic [1:0] parity_mode_i,
  input  logic       rx_fifo_read_i,
  output logic [7:0] data_rx_o,
  output logic       rx_fifo_empty_o,
  output logic       rx_fifo_full_o,
  output logic       rx_done_o,
  output logic       parity_error_o,
  output logic       frame_error_o,
  output logic       overrun_error_o,
  output logic       config_req_slv_o
);

  // state  | meaning
  // IDLE   | line idle, waiting for a falling edge
  // START  | qualifying the start bit at its centre
  // DATA   | sampling data bits LSB first
  // PARITY | sampling the parity bit
  // STOP   | sampling one or two stop bits
  // BREAK  | stop bit was low, waiting for the line to return high
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  localparam int COUNT_10MS = CLK_FREQ_HZ / 100;
  localparam int LCW        = $clog2(COUNT_10MS + 1);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam logic [LCW-1:0] LOW_MAX  = LCW'(COUNT_10MS);
  localparam logic [LCW-1:0] LOW_LAST = LCW'(COUNT_10MS - 1);
  localparam logic [AW:0]    PTR_ONE  = (AW+1)'(1);

  state_t       r_state;
  logic         r_rx_meta, r_rx_s;
  logic [3:0]   r_cnt;
  logic [2:0]   r_bit_idx, r_last_idx;
  logic [7:0]   r_shreg;
  logic         r_two_stop, r_second_stop, r_par_en, r_odd, r_perr;
  logic         r_rx_done, r_par_err, r_frame_err;
  logic [LCW-1:0] r_low_cnt;
  logic         r_cfg_req;
  logic [7:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]  r_wptr, r_rptr;
  logic         w_empty, w_full, w_rd, w_wr;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_bit_idx     <= 3'd0;
      r_last_idx    <= 3'd7;
      r_shreg       <= 8'h00;
      r_two_stop    <= 1'b0;
      r_second_stop <= 1'b0;
      r_par_en      <= 1'b0;
      r_odd         <= 1'b0;
      r_perr        <= 1'b0;
      r_rx_done     <= 1'b0;
      r_par_err     <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_rx_done   <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state <= S_START;
            r_cnt   <= 4'd0;
          end
        end
        S_START: begin
          if (ov_baud_rt_i) begin
            if (r_cnt == 4'd7) begin
              r_cnt <= 4'd0;
              if (!r_rx_s) begin
                // frame configuration is frozen here for the whole frame
                r_state       <= S_DATA;
                r_last_idx    <= {1'b0, data_width_i} + 3'd4;
                r_two_stop    <= (stop_bits_number_i == 2'b01);
                r_par_en      <= ~parity_mode_i[1];
                r_odd         <= parity_mode_i[0];
                r_bit_idx     <= 3'd0;
                r_shreg       <= 8'h00;
                r_second_stop <= 1'b0;
                r_perr        <= 1'b0;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (ov_baud_rt_i) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_shreg[r_bit_idx] <= r_rx_s;
              r_bit_idx          <= r_bit_idx + 3'd1;
              if (r_bit_idx == r_last_idx)
                r_state <= r_par_en ? S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (ov_baud_rt_i) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_perr  <= (^r_shreg) ^ r_rx_s ^ r_odd;
              r_state <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (ov_baud_rt_i) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              if (!r_rx_s) begin
                r_frame_err <= 1'b1;
                r_state     <= S_BREAK;
              end else if (r_two_stop && !r_second_stop) begin
                r_second_stop <= 1'b1;
              end else begin
                // return to IDLE mid-stop so the next falling edge is caught promptly
                r_rx_done <= 1'b1;
                r_par_err <= r_perr;
                r_state   <= S_IDLE;
              end
            end
          end
        end
        S_BREAK: begin
          if (r_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_low_cnt <= '0;
      r_cfg_req <= 1'b0;
    end else begin
      r_cfg_req <= 1'b0;
      if (r_rx_s) begin
        r_low_cnt <= '0;
      end else if (r_low_cnt != LOW_MAX) begin
        r_low_cnt <= r_low_cnt + LCW'(1);
        if (r_low_cnt == LOW_LAST) r_cfg_req <= 1'b1;
      end
    end
  end

  // the received word stays in r_shreg for the cycle rx_done_o is high; it is written then
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_rd    = rx_fifo_read_i & ~w_empty;
  assign w_wr    = r_rx_done & (~w_full | w_rd);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PTR_ONE;
      if (w_rd) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= r_shreg;
  end

  assign data_rx_o        = w_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];
  assign rx_fifo_empty_o  = w_empty;
  assign rx_fifo_full_o   = w_full;
  assign rx_done_o        = r_rx_done;
  assign parity_error_o   = r_par_err;
  assign frame_error_o    = r_frame_err;
  assign overrun_error_o  = r_rx_done & w_full & ~rx_fifo_read_i;
  assign config_req_slv_o = r_cfg_req;

endmodule
